instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch stage of the MPU core. It sits directly upstream of the decode/ctrl block and owns the program counter. It issues word reads to instruction memory and buffers returned words with their PCs in a small FIFO. It presents the head instruction and its pre-sliced opcode, func3 and func7 fields to ctrl under a valid/ready handshake, and restarts fetch at a new PC when ctrl or the branch unit redirects.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, instruction buffer entries; power of 2, minimum 2.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
imem_req  out  1  request strobe; one-cycle pulse per fetch.
imem_addr  out  32  word address of the request; valid while imem_req=1.
imem_rvalid  in  1  read data valid; exactly one pulse per request, at least 1 cycle after it.
imem_rdata  in  32  instruction word; sampled when imem_rvalid=1.
redirect  in  1  flush and restart fetch (taken branch, JAL, JALR).
redirect_pc  in  32  new fetch PC; bits [1:0] ignored and treated as 0.
instr_ready  in  1  ctrl accepts the head instruction this cycle.
instr_valid  out  1  head entry valid.
instr  out  32  head instruction word.
instr_pc  out  32  PC of the head instruction.
opcode  out  5  instr[6:2].
func3  out  3  instr[14:12].
func7  out  7  instr[31:25].
illegal  out  1  head valid and instr[1:0] != 2'b11.

Behaviour:
- Reset values (cycle after rst=1): pc=RESET_PC, FIFO empty, instr_valid=0, illegal=0, imem_req=0, state=FETCH. instr, instr_pc, opcode, func3 and func7 read 0 while the FIFO is empty.
- FSM states:
  - FETCH: assert imem_req with imem_addr=pc when occupancy (FIFO count plus outstanding) < FIFO_DEPTH. Then pc <= pc+4 (mod 2^32) and go to WAIT. Otherwise hold in FETCH with imem_req=0.
  - WAIT: on imem_rvalid, push {pc_of_request, imem_rdata} into the FIFO and go to FETCH.
  - DROP: wait for the stale response. On imem_rvalid, discard the data and go to FETCH.
- At most one request outstanding at any time. imem_req is never asserted in WAIT or DROP.
- Latency: first imem_req in the first cycle after rst deasserts. rvalid in cycle N gives instr_valid=1 in cycle N+1 (registered, no bypass). Back-to-back throughput with 1-cycle memory is 1 instruction per 2 cycles.
- Handshake: a pop occurs when instr_valid & instr_ready. Head outputs stay stable while instr_valid=1 and instr_ready=0. A push and a pop in the same cycle leave the count unchanged.
- Full FIFO: no request issued. A pop in the same cycle frees a slot, and the request issues in the next cycle.
- Redirect has priority over push, pop and request in the same cycle:
  - FIFO cleared and pc <= {redirect_pc[31:2], 2'b00}.
  - instr_valid=0 from the next cycle.
  - No imem_req in the redirect cycle.
  - From WAIT (or WAIT with rvalid not yet seen), go to DROP. If imem_rvalid arrives in the redirect cycle itself, discard it and go to FETCH.
  - From FETCH, go to FETCH.
- Redirect while in DROP: update pc only and stay in DROP. Exactly one response is still owed.
- rst overrides everything, including mid-WAIT. An imem_rvalid arriving after reset with no request outstanding is ignored.
- Field slicing is combinational from the FIFO head.

Test Plan:
- Reset/boot: rst=1 for 2 cycles, then 0. imem_req=1 with imem_addr=0x0 in the first cycle after release. Return rdata=0x00500093 (addi). Next cycle: instr_valid=1, instr_pc=0, opcode=5'b00100, func3=0, illegal=0.
- Streaming: instr_ready=1 and memory latency 1. Addresses issued are 0x0, 0x4, 0x8, 0xC. instr_pc sequence on outputs matches, with no duplicates or gaps.
- Back-pressure: instr_ready=0 with FIFO_DEPTH=2. Exactly 2 requests issue, then imem_req stays 0 and the head stays 0x0 with stable instr. Raise ready for 1 cycle: one pop, and the next request issues one cycle later.
- Redirect with request in flight: redirect=1, redirect_pc=0x103 in WAIT. The next rvalid (rdata=0xDEADBEEF) is dropped. The following imem_addr=0x100. The first valid instr_pc is 0x100, and 0xDEADBEEF never appears on instr.
- Redirect colliding with pop and rvalid in the same cycle: FIFO empty next cycle, the rvalid data is discarded, and the next fetch is at redirect_pc.
- Reset mid-operation and illegal: assert rst during WAIT. Outputs return to reset values and the late rvalid is ignored. Separately, return 0x00000000: illegal=1 while it is head-valid.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory, buffers returned words with their PCs, and presents
// the head entry (with pre-sliced decode fields) to ctrl via valid/ready.
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        instr_ready,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [4:0]  opcode,
   output logic [2:0]  func3,
   output logic [6:0]  func7,
   output logic        illegal
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_DROP  = 2'd2
   } state_t;

   state_t             r_state;
   logic [31:0]        r_pc;
   logic [31:0]        r_req_pc;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [31:0]        r_buf_instr [FIFO_DEPTH];
   logic [31:0]        r_buf_pc    [FIFO_DEPTH];

   logic               w_empty;
   logic               w_room;
   logic               w_push;
   logic               w_pop;
   logic [31:0]        w_head_instr;
   logic [31:0]        w_head_pc;

   // Only one request is ever outstanding, and requests are only made from
   // FETCH, so occupancy there is simply the buffer count. The full check uses
   // the registered count: a pop this cycle frees a slot for next cycle only.
   assign w_empty = (r_count == '0);
   assign w_room  = (r_count < CNT_W'(FIFO_DEPTH));

   // The strobe is decoded from state so a redirect in the same cycle can
   // suppress it; the address is the registered PC.
   assign imem_req  = !rst && !redirect && (r_state == S_FETCH) && w_room;
   assign imem_addr = r_pc;

   // Redirect beats push and pop; a response seen in DROP or FETCH is stale.
   assign w_push = !rst && !redirect && (r_state == S_WAIT) && imem_rvalid;
   assign w_pop  = !rst && !redirect && !w_empty && instr_ready;

   // Fetch control: PC sequencing, request tracking, stale-response dropping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_FETCH;
         r_pc     <= {RESET_PC[31:2], 2'b00};
         r_req_pc <= {RESET_PC[31:2], 2'b00};
      end else if (redirect) begin
         r_pc <= {redirect_pc[31:2], 2'b00};
         case (r_state)
            S_FETCH: r_state <= S_FETCH;
            // A response arriving in the redirect cycle settles the debt now;
            // otherwise one response is still owed and must be discarded.
            S_WAIT,
            S_DROP:  r_state <= imem_rvalid ? S_FETCH : S_DROP;
            default: r_state <= S_FETCH;
         endcase
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_req) begin
                  r_req_pc <= r_pc;
                  r_pc     <= r_pc + 32'd4;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  r_state <= S_FETCH;
               end
            end
            S_DROP: begin
               if (imem_rvalid) begin
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

   // Buffer pointers and count; reset and redirect both empty the buffer.
   always_ff @(posedge clk) begin
      if (rst || redirect) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Per-entry storage: each slot captures the returned word and its PC.
   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      // Write this slot when the push targets it.
      always_ff @(posedge clk) begin
         if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
            r_buf_instr[gi] <= imem_rdata;
            r_buf_pc[gi]    <= r_req_pc;
         end
      end
   end

   assign w_head_instr = r_buf_instr[r_rd_ptr];
   assign w_head_pc    = r_buf_pc[r_rd_ptr];

   // Head outputs read zero when empty so stale slot contents never leak.
   assign instr_valid = !w_empty;
   assign instr       = w_empty ? 32'h0 : w_head_instr;
   assign instr_pc    = w_empty ? 32'h0 : w_head_pc;
   assign opcode      = instr[6:2];
   assign func3       = instr[14:12];
   assign func7       = instr[31:25];
   assign illegal     = !w_empty && (instr[1:0] != 2'b11);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: boot, streaming, back-pressure,
// redirects (in flight and colliding with pop/rvalid), reset mid-WAIT, illegal.
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_ready;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [4:0]  opcode;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic        illegal;

   int checks   = 0;
   int failures = 0;

   logic        mem_auto;
   logic [31:0] issued_q[$];
   logic [31:0] pop_pc_q[$];
   logic [31:0] pop_instr_q[$];

   instr_fetch #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_ready (instr_ready),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .opcode      (opcode),
      .func3       (func3),
      .func7       (func7),
      .illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory image: addi x0,x0,imm with the low address bits as immediate.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return {addr[11:0], 20'h00013};
   endfunction

   // One clock: log request/pop seen before the edge, then (auto mode)
   // answer the request one cycle later.
   task automatic tick();
      logic        was_req;
      logic [31:0] was_addr;
      #1;
      was_req  = imem_req;
      was_addr = imem_addr;
      if (was_req) issued_q.push_back(was_addr);
      if (!rst && !redirect && instr_valid && instr_ready) begin
         pop_pc_q.push_back(instr_pc);
         pop_instr_q.push_back(instr);
         $display("pop pc=%08h instr=%08h", instr_pc, instr);
      end
      @(posedge clk);
      #1;
      if (mem_auto) begin
         imem_rvalid = was_req;
         imem_rdata  = was_req ? mem_word(was_addr) : 32'h0;
      end
   endtask

   task automatic apply_reset();
      mem_auto    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      issued_q.delete();
      pop_pc_q.delete();
      pop_instr_q.delete();
      #1;
   endtask

   task automatic test_reset();
      mem_auto    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      #1;
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b expected 0", instr_valid); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %0b expected 0", imem_req); end
      checks++; if (instr !== 32'h0 || instr_pc !== 32'h0 || illegal !== 1'b0) begin failures++; $display("FAIL rst_head: got instr=%08h pc=%08h ill=%0b expected 0/0/0", instr, instr_pc, illegal); end
      rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL boot_req: got req=%0b addr=%08h expected 1/00000000", imem_req, imem_addr); end
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0050_0093;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL boot_wait_req: got %0b expected 0", imem_req); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL boot_no_bypass: got %0b expected 0", instr_valid); end
      tick();
      imem_rvalid = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL boot_valid: got %0b expected 1", instr_valid); end
      checks++; if (instr !== 32'h0050_0093 || instr_pc !== 32'h0) begin failures++; $display("FAIL boot_head: got instr=%08h pc=%08h expected 00500093/00000000", instr, instr_pc); end
      checks++; if (opcode !== 5'b00100 || func3 !== 3'd0 || func7 !== 7'd0 || illegal !== 1'b0) begin failures++; $display("FAIL boot_fields: got op=%b f3=%0d f7=%0d ill=%0b expected 00100/0/0/0", opcode, func3, func7, illegal); end
   endtask

   task automatic test_streaming();
      apply_reset();
      mem_auto    = 1'b1;
      instr_ready = 1'b1;
      repeat (12) tick();
      instr_ready = 1'b0;
      checks++; if (issued_q.size() != 6) begin failures++; $display("FAIL stream_req_count: got %0d expected 6", issued_q.size()); end
      checks++; if (pop_pc_q.size() != 5) begin failures++; $display("FAIL stream_pop_count: got %0d expected 5", pop_pc_q.size()); end
      for (int i = 0; i < 5; i++) begin
         logic [31:0] exp_pc;
         exp_pc = 32'(i) * 32'd4;
         if (issued_q.size() > i) begin
            checks++; if (issued_q[i] !== exp_pc) begin failures++; $display("FAIL stream_addr%0d: got %08h expected %08h", i, issued_q[i], exp_pc); end
         end
         if (pop_pc_q.size() > i) begin
            checks++; if (pop_pc_q[i] !== exp_pc) begin failures++; $display("FAIL stream_pc%0d: got %08h expected %08h", i, pop_pc_q[i], exp_pc); end
            checks++; if (pop_instr_q[i] !== mem_word(exp_pc)) begin failures++; $display("FAIL stream_instr%0d: got %08h expected %08h", i, pop_instr_q[i], mem_word(exp_pc)); end
         end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      mem_auto    = 1'b1;
      instr_ready = 1'b0;
      repeat (5) tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin failures++; $display("FAIL bp_stable%0d: got pc=%08h instr=%08h expected 00000000/%08h", i, instr_pc, instr, mem_word(32'h0)); end
      end
      #1;
      checks++; if (issued_q.size() != 2) begin failures++; $display("FAIL bp_req_count: got %0d expected 2", issued_q.size()); end
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin failures++; $display("FAIL bp_full: got req=%0b valid=%0b expected 0/1", imem_req, instr_valid); end
      instr_ready = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_pop_cycle_req: got %0b expected 0", imem_req); end
      tick();
      instr_ready = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL bp_next_req: got req=%0b addr=%08h expected 1/00000008", imem_req, imem_addr); end
      checks++; if (instr_pc !== 32'h4 || pop_pc_q.size() != 1) begin failures++; $display("FAIL bp_one_pop: got pc=%08h pops=%0d expected 00000004/1", instr_pc, pop_pc_q.size()); end
   endtask

   task automatic test_redirect_inflight();
      apply_reset();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_cycle_req: got %0b expected 0", imem_req); end
      tick();
      redirect = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL redir_drop_wait: got req=%0b valid=%0b expected 0/0", imem_req, instr_valid); end
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0 || instr === 32'hDEAD_BEEF) begin failures++; $display("FAIL redir_dropped: got valid=%0b instr=%08h expected 0/not deadbeef", instr_valid, instr); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL redir_addr: got req=%0b addr=%08h expected 1/00000100", imem_req, imem_addr); end
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(32'h100);
      tick();
      imem_rvalid = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin failures++; $display("FAIL redir_first: got valid=%0b pc=%08h instr=%08h expected 1/00000100/%08h", instr_valid, instr_pc, instr, mem_word(32'h100)); end
   endtask

   task automatic test_redirect_collision();
      apply_reset();
      mem_auto    = 1'b1;
      instr_ready = 1'b0;
      tick();
      tick();
      tick();
      instr_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      #1;
      checks++; if (instr_valid !== 1'b1 || imem_rvalid !== 1'b1) begin failures++; $display("FAIL coll_setup: got valid=%0b rvalid=%0b expected 1/1", instr_valid, imem_rvalid); end
      tick();
      redirect    = 1'b0;
      instr_ready = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin failures++; $display("FAIL coll_empty: got valid=%0b instr=%08h expected 0/00000000", instr_valid, instr); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL coll_addr: got req=%0b addr=%08h expected 1/00000200", imem_req, imem_addr); end
      tick();
      tick();
      #1;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== mem_word(32'h200)) begin failures++; $display("FAIL coll_first: got valid=%0b pc=%08h instr=%08h expected 1/00000200/%08h", instr_valid, instr_pc, instr, mem_word(32'h200)); end
   endtask

   task automatic test_reset_midwait();
      apply_reset();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h1111_1113;
      #1;
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || illegal !== 1'b0) begin failures++; $display("FAIL rmid_outputs: got valid=%0b instr=%08h pc=%08h ill=%0b expected 0/0/0/0", instr_valid, instr, instr_pc, illegal); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rmid_req: got req=%0b addr=%08h expected 1/00000000", imem_req, imem_addr); end
      tick();
      imem_rvalid = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rmid_late_ignored: got %0b expected 0", instr_valid); end
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(32'h0);
      tick();
      imem_rvalid = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h0)) begin failures++; $display("FAIL rmid_refetch: got valid=%0b instr=%08h expected 1/%08h", instr_valid, instr, mem_word(32'h0)); end
   endtask

   task automatic test_illegal();
      apply_reset();
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_0000;
      tick();
      imem_rvalid = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b1 || illegal !== 1'b1) begin failures++; $display("FAIL ill_set: got valid=%0b ill=%0b expected 1/1", instr_valid, illegal); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL ill_clear: got valid=%0b ill=%0b expected 0/0", instr_valid, illegal); end
   endtask

   initial begin
      rst         = 1'b1;
      mem_auto    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_collision();
      test_reset_midwait();
      test_illegal();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
